// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants, FSM state type and decode helpers for the MEM stage
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

    // Access size in bytes; the low two funct3 bits encode size for both loads and stores.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // wide = 1 when XLEN is 64, which enables the doubleword and unsigned-word encodings.
    function automatic logic funct3_legal(input logic is_load, input logic [2:0] funct3,
                                          input logic wide);
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: return 1'b1;
                F3_LD, F3_LWU:                       return wide;
                default:                             return 1'b0;
            endcase
        end else begin
            case (funct3)
                F3_SB, F3_SH, F3_SW: return 1'b1;
                F3_SD:               return wide;
                default:             return 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory req/gnt/rvalid bus
// master: the MEM stage (drives dmem_req/we/addr/be/wdata, receives dmem_gnt/rvalid/rdata)
// slave:  the data memory
interface mem_access_unit_if #(
    parameter int XLEN            = 32,
    parameter int DMEM_ADDR_WIDTH = 8
);
    localparam int NUM_COL = XLEN / 8;

    logic                       dmem_req;
    logic                       dmem_gnt;
    logic                       dmem_we;
    logic [DMEM_ADDR_WIDTH-1:0] dmem_addr;
    logic [NUM_COL-1:0]         dmem_be;
    logic [XLEN-1:0]            dmem_wdata;
    logic                       dmem_rvalid;
    logic [XLEN-1:0]            dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects load lanes from a memory word and sign/zero-extends them
// Ports: rdata (memory word), offset (byte offset inside the word), funct3 (load kind),
//        result (extended XLEN value)
module load_extend
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              result
);
    logic [XLEN-1:0] sh;

    always_comb begin
        sh = rdata >> {offset, 3'b000};
        result = sh;
        case (funct3)
            F3_LB:   result = XLEN'($signed(sh[7:0]));
            F3_LH:   result = XLEN'($signed(sh[15:0]));
            F3_LW:   result = XLEN'($signed(sh[31:0]));
            F3_LBU:  result = XLEN'(sh[7:0]);
            F3_LHU:  result = XLEN'(sh[15:0]);
            F3_LWU:  result = XLEN'(sh[31:0]);
            default: result = sh;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM pipeline stage driving a variable-latency data memory
// Ports: clk, reset (sync, active-high); in_* op from EX/MEM with in_valid/in_ready;
//        dmem (mem_access_unit_if.master) data-memory bus; wb_* MEM/WB payload with wb_valid pulse.
// Build option: MISALIGN_TRAP_EN - trap misaligned accesses instead of rounding the offset down.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int DMEM_ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_wr_en,
    input  logic [1:0]            in_reg_wr_ctrl,
    input  logic [XLEN-1:0]       in_pc_4,
    input  logic                  in_halt,
    mem_access_unit_if.master     dmem,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_alu_out,
    output logic [XLEN-1:0]       wb_pc_4,
    output logic [XLEN-1:0]       wb_load_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_reg_wr_en,
    output logic [1:0]            wb_reg_wr_ctrl,
    output logic                  wb_halt,
    output logic                  wb_exc
);
    localparam int NUM_COL = XLEN / 8;
    localparam int OFF_W   = $clog2(NUM_COL);

    if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
        $error("mem_access_unit: XLEN must be 32 or 64");
    end

    state_t state;

    // Op fields held for the retire of a memory access.
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  pc4_q;
    logic [4:0]       rd_q;
    logic             wr_en_q;
    logic [1:0]       wr_ctrl_q;
    logic             halt_q;
    logic [2:0]       f3_q;
    logic [OFF_W-1:0] off_q;

    logic             is_mem;
    logic             legal;
    logic             misaligned;
    logic             bad;
    logic [3:0]       sz;
    logic [7:0]       run;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] off_mask;
    logic [OFF_W-1:0] off_al;
    logic [NUM_COL-1:0] be_next;
    logic [XLEN-1:0]  wdata_next;
    logic [XLEN-1:0]  ext_data;
    logic             retire_mem;

    assign in_ready = (state == IDLE);

    always_comb begin
        is_mem   = in_is_load | in_is_store;
        legal    = funct3_legal(in_is_load, in_funct3, XLEN == 64);
        sz       = size_bytes(in_funct3);
        off      = in_addr[OFF_W-1:0];
        off_mask = OFF_W'(sz - 4'd1);
`ifdef MISALIGN_TRAP_EN
        misaligned = |(off & off_mask);
        off_al     = off;
`else
        misaligned = 1'b0;
        off_al     = off & ~off_mask;
`endif
        bad = is_mem & (~legal | misaligned);
        case (sz)
            4'd1:    run = 8'h01;
            4'd2:    run = 8'h03;
            4'd4:    run = 8'h0F;
            default: run = 8'hFF;
        endcase
        be_next    = NUM_COL'(run) << off_al;
        wdata_next = in_store_data << {off_al, 3'b000};
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata  (dmem.dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    // A memory op retires on gnt for a store, or on rvalid while waiting for load data.
    assign retire_mem = (state == REQ && dmem.dmem_gnt && dmem.dmem_we) ||
                        (state == WAIT_RD && dmem.dmem_rvalid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            wb_valid        <= 1'b0;
            wb_alu_out      <= '0;
            wb_pc_4         <= '0;
            wb_load_data    <= '0;
            wb_rd           <= '0;
            wb_reg_wr_en    <= 1'b0;
            wb_reg_wr_ctrl  <= '0;
            wb_halt         <= 1'b0;
            wb_exc          <= 1'b0;
            alu_q           <= '0;
            pc4_q           <= '0;
            rd_q            <= '0;
            wr_en_q         <= 1'b0;
            wr_ctrl_q       <= '0;
            halt_q          <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_q     <= in_addr;
                        pc4_q     <= in_pc_4;
                        rd_q      <= in_rd;
                        wr_en_q   <= in_reg_wr_en;
                        wr_ctrl_q <= in_reg_wr_ctrl;
                        halt_q    <= in_halt;
                        f3_q      <= in_funct3;
                        off_q     <= off_al;
                        if (is_mem && !bad) begin
                            state           <= REQ;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= in_is_store & ~in_is_load;
                            dmem.dmem_addr  <= in_addr[DMEM_ADDR_WIDTH+OFF_W-1:OFF_W];
                            dmem.dmem_be    <= be_next;
                            dmem.dmem_wdata <= wdata_next;
                        end else begin
                            // ALU ops and faulting accesses retire straight from IDLE.
                            wb_valid       <= 1'b1;
                            wb_alu_out     <= in_addr;
                            wb_pc_4        <= in_pc_4;
                            wb_load_data   <= '0;
                            wb_rd          <= in_rd;
                            wb_reg_wr_en   <= in_reg_wr_en & ~bad;
                            wb_reg_wr_ctrl <= in_reg_wr_ctrl;
                            wb_halt        <= in_halt;
                            wb_exc         <= bad;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt) begin
                        dmem.dmem_req <= 1'b0;
                        state         <= dmem.dmem_we ? IDLE : WAIT_RD;
                    end
                end
                WAIT_RD: begin
                    if (dmem.dmem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (retire_mem) begin
                wb_valid       <= 1'b1;
                wb_alu_out     <= alu_q;
                wb_pc_4        <= pc4_q;
                wb_load_data   <= (state == WAIT_RD) ? ext_data : '0;
                wb_rd          <= rd_q;
                wb_reg_wr_en   <= wr_en_q;
                wb_reg_wr_ctrl <= wr_ctrl_q;
                wb_halt        <= halt_q;
                wb_exc         <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit (XLEN=32)
module tb_mem_access_unit;
    localparam int XLEN = 32;
    localparam int AW   = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_addr;
    logic [2:0]      in_funct3;
    logic            in_is_load;
    logic            in_is_store;
    logic [XLEN-1:0] in_store_data;
    logic [4:0]      in_rd;
    logic            in_reg_wr_en;
    logic [1:0]      in_reg_wr_ctrl;
    logic [XLEN-1:0] in_pc_4;
    logic            in_halt;
    logic            wb_valid;
    logic [XLEN-1:0] wb_alu_out;
    logic [XLEN-1:0] wb_pc_4;
    logic [XLEN-1:0] wb_load_data;
    logic [4:0]      wb_rd;
    logic            wb_reg_wr_en;
    logic [1:0]      wb_reg_wr_ctrl;
    logic            wb_halt;
    logic            wb_exc;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if #(.XLEN(XLEN), .DMEM_ADDR_WIDTH(AW)) dmem_bus ();

    mem_access_unit #(.XLEN(XLEN), .DMEM_ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_addr        (in_addr),
        .in_funct3      (in_funct3),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_wr_en   (in_reg_wr_en),
        .in_reg_wr_ctrl (in_reg_wr_ctrl),
        .in_pc_4        (in_pc_4),
        .in_halt        (in_halt),
        .dmem           (dmem_bus),
        .wb_valid       (wb_valid),
        .wb_alu_out     (wb_alu_out),
        .wb_pc_4        (wb_pc_4),
        .wb_load_data   (wb_load_data),
        .wb_rd          (wb_rd),
        .wb_reg_wr_en   (wb_reg_wr_en),
        .wb_reg_wr_ctrl (wb_reg_wr_ctrl),
        .wb_halt        (wb_halt),
        .wb_exc         (wb_exc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and returns just after the edge that accepts it.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input logic wr_en);
        in_valid      = 1'b1;
        in_is_load    = ld;
        in_is_store   = st;
        in_funct3     = f3;
        in_addr       = addr;
        in_store_data = sdata;
        in_rd         = rd;
        in_reg_wr_en  = wr_en;
        in_pc_4       = addr + 32'd4;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req: got %b expected 0", dmem_bus.dmem_req); end
        checks++; if (dmem_bus.dmem_be !== 4'b0000) begin errors++; $display("FAIL reset_dmem_be: got %b expected 0000", dmem_bus.dmem_be); end
        checks++; if (wb_valid !== 1'b0 || wb_exc !== 1'b0) begin errors++; $display("FAIL reset_wb_flags: got valid=%b exc=%b expected 0 0", wb_valid, wb_exc); end
        checks++; if (wb_load_data !== 32'h0 || wb_alu_out !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got load=%h alu=%h expected 0 0", wb_load_data, wb_alu_out); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_store_word();
        dmem_bus.dmem_gnt = 1'b1;
        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
        checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b1) begin errors++; $display("FAIL sw_req: got req=%b we=%b expected 1 1", dmem_bus.dmem_req, dmem_bus.dmem_we); end
        checks++; if (dmem_bus.dmem_addr !== 8'd4) begin errors++; $display("FAIL sw_addr: got %h expected 04", dmem_bus.dmem_addr); end
        checks++; if (dmem_bus.dmem_be !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b expected 1111", dmem_bus.dmem_be); end
        checks++; if (dmem_bus.dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected deadbeef", dmem_bus.dmem_wdata); end
        checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL sw_busy: got ready=%b valid=%b expected 0 0", in_ready, wb_valid); end
        step();
        checks++; if (wb_valid !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL sw_retire: got valid=%b req=%b expected 1 0", wb_valid, dmem_bus.dmem_req); end
        checks++; if (wb_alu_out !== 32'h10 || wb_exc !== 1'b0) begin errors++; $display("FAIL sw_payload: got alu=%h exc=%b expected 10 0", wb_alu_out, wb_exc); end
        step();
        checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL sw_pulse: got valid=%b ready=%b expected 0 1", wb_valid, in_ready); end
        dmem_bus.dmem_gnt = 1'b0;
    endtask

    task automatic test_store_byte();
        dmem_bus.dmem_gnt = 1'b1;
        issue(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000A5, 5'd0, 1'b0);
        checks++; if (dmem_bus.dmem_be !== 4'b1000) begin errors++; $display("FAIL sb_be: got %b expected 1000", dmem_bus.dmem_be); end
        checks++; if (dmem_bus.dmem_wdata !== 32'hA5000000) begin errors++; $display("FAIL sb_wdata: got %h expected a5000000", dmem_bus.dmem_wdata); end
        checks++; if (dmem_bus.dmem_addr !== 8'd4) begin errors++; $display("FAIL sb_addr: got %h expected 04", dmem_bus.dmem_addr); end
        step();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sb_retire: got %b expected 1", wb_valid); end
        dmem_bus.dmem_gnt = 1'b0;
        step();
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        dmem_bus.dmem_gnt   = 1'b1;
        dmem_bus.dmem_rdata = 32'hA5000000;
        issue(1'b1, 1'b0, f3, 32'h13, 32'h0, 5'd7, 1'b1);
        checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_we !== 1'b0 || dmem_bus.dmem_be !== 4'b1000) begin errors++; $display("FAIL lb_req: got req=%b we=%b be=%b expected 1 0 1000", dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_be); end
        step();
        dmem_bus.dmem_gnt = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wait: got req=%b valid=%b expected 0 0", dmem_bus.dmem_req, wb_valid); end
        dmem_bus.dmem_rvalid = 1'b1;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lb_valid f3=%b: got %b expected 1", f3, wb_valid); end
        checks++; if (wb_load_data !== exp) begin errors++; $display("FAIL lb_data f3=%b: got %h expected %h", f3, wb_load_data, exp); end
        checks++; if (wb_rd !== 5'd7 || wb_reg_wr_en !== 1'b1) begin errors++; $display("FAIL lb_rd: got rd=%0d wr=%b expected 7 1", wb_rd, wb_reg_wr_en); end
        step();
    endtask

    task automatic test_load_half_stall();
        dmem_bus.dmem_gnt   = 1'b0;
        dmem_bus.dmem_rdata = 32'h80010000;
        issue(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, 5'd9, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 8'd8 || dmem_bus.dmem_be !== 4'b1100) begin errors++; $display("FAIL lh_hold c%0d: got req=%b addr=%h be=%b expected 1 08 1100", c, dmem_bus.dmem_req, dmem_bus.dmem_addr, dmem_bus.dmem_be); end
            checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL lh_busy c%0d: got ready=%b valid=%b expected 0 0", c, in_ready, wb_valid); end
            step();
        end
        dmem_bus.dmem_gnt = 1'b1;
        step();
        dmem_bus.dmem_gnt = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL lh_wait: got req=%b valid=%b ready=%b expected 0 0 0", dmem_bus.dmem_req, wb_valid, in_ready); end
        step();
        dmem_bus.dmem_rvalid = 1'b1;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_load_data !== 32'hFFFF8001) begin errors++; $display("FAIL lh_retire: got valid=%b data=%h expected 1 ffff8001", wb_valid, wb_load_data); end
        step();
    endtask

    task automatic test_alu();
        in_reg_wr_ctrl = 2'b01;
        issue(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        checks++; if (wb_valid !== 1'b1 || wb_alu_out !== 32'h1234) begin errors++; $display("FAIL alu_retire: got valid=%b alu=%h expected 1 1234", wb_valid, wb_alu_out); end
        checks++; if (wb_rd !== 5'd5 || wb_pc_4 !== 32'h1238 || wb_reg_wr_ctrl !== 2'b01) begin errors++; $display("FAIL alu_payload: got rd=%0d pc4=%h ctrl=%b expected 5 1238 01", wb_rd, wb_pc_4, wb_reg_wr_ctrl); end
        checks++; if (dmem_bus.dmem_req !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL alu_nomem: got req=%b ready=%b expected 0 1", dmem_bus.dmem_req, in_ready); end
        step();
        checks++; if (wb_valid !== 1'b0 || wb_alu_out !== 32'h1234) begin errors++; $display("FAIL alu_hold: got valid=%b alu=%h expected 0 1234", wb_valid, wb_alu_out); end
        in_reg_wr_ctrl = 2'b00;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0;
        in_addr = 32'h111; in_rd = 5'd1;
        step();
        checks++; if (wb_valid !== 1'b1 || wb_alu_out !== 32'h111) begin errors++; $display("FAIL b2b_first: got valid=%b alu=%h expected 1 111", wb_valid, wb_alu_out); end
        in_addr = 32'h222; in_rd = 5'd2;
        step();
        in_valid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_alu_out !== 32'h222 || wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_second: got valid=%b alu=%h rd=%0d expected 1 222 2", wb_valid, wb_alu_out, wb_rd); end
        step();
    endtask

    task automatic test_illegal();
        issue(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 5'd3, 1'b1);
        checks++; if (wb_valid !== 1'b1 || wb_exc !== 1'b1 || wb_reg_wr_en !== 1'b0 || dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ld_illegal: got valid=%b exc=%b wr=%b req=%b expected 1 1 0 0", wb_valid, wb_exc, wb_reg_wr_en, dmem_bus.dmem_req); end
        step();
        issue(1'b0, 1'b1, 3'b100, 32'h40, 32'h0, 5'd0, 1'b0);
        checks++; if (wb_valid !== 1'b1 || wb_exc !== 1'b1 || dmem_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL st_illegal: got valid=%b exc=%b req=%b expected 1 1 0", wb_valid, wb_exc, dmem_bus.dmem_req); end
        step();
    endtask

    task automatic test_misalign();
        dmem_bus.dmem_gnt   = 1'b1;
        dmem_bus.dmem_rdata = 32'h11223344;
        issue(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 5'd4, 1'b1);
`ifdef MISALIGN_TRAP_EN
        checks++; if (dmem_bus.dmem_req !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL mis_trap: got req=%b valid=%b expected 0 1", dmem_bus.dmem_req, wb_valid); end
        checks++; if (wb_exc !== 1'b1 || wb_reg_wr_en !== 1'b0) begin errors++; $display("FAIL mis_exc: got exc=%b wr=%b expected 1 0", wb_exc, wb_reg_wr_en); end
        dmem_bus.dmem_gnt = 1'b0;
        step();
`else
        checks++; if (dmem_bus.dmem_req !== 1'b1 || dmem_bus.dmem_addr !== 8'd1 || dmem_bus.dmem_be !== 4'b1111) begin errors++; $display("FAIL mis_round: got req=%b addr=%h be=%b expected 1 01 1111", dmem_bus.dmem_req, dmem_bus.dmem_addr, dmem_bus.dmem_be); end
        step();
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b1;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1 || wb_load_data !== 32'h11223344 || wb_exc !== 1'b0) begin errors++; $display("FAIL mis_load: got valid=%b data=%h exc=%b expected 1 11223344 0", wb_valid, wb_load_data, wb_exc); end
        step();
`endif
    endtask

    task automatic test_reset_wait_rd();
        dmem_bus.dmem_gnt = 1'b1;
        issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 5'd6, 1'b1);
        step();
        dmem_bus.dmem_gnt = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_pre: got ready=%b expected 0", in_ready); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (dmem_bus.dmem_req !== 1'b0 || in_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL rst_mid: got req=%b ready=%b valid=%b expected 0 1 0", dmem_bus.dmem_req, in_ready, wb_valid); end
        dmem_bus.dmem_rvalid = 1'b1;
        step();
        dmem_bus.dmem_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_late_rvalid: got valid=%b ready=%b expected 0 1", wb_valid, in_ready); end
        step();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_funct3 = '0;
        in_is_load = 1'b0; in_is_store = 1'b0; in_store_data = '0; in_rd = '0;
        in_reg_wr_en = 1'b0; in_reg_wr_ctrl = '0; in_pc_4 = '0; in_halt = 1'b0;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        #1;
        test_reset();
        test_store_word();
        test_store_byte();
        test_load_byte(3'b000, 32'hFFFFFFA5);
        test_load_byte(3'b100, 32'h000000A5);
        test_load_half_stall();
        test_alu();
        test_back_to_back();
        test_illegal();
        test_misalign();
        test_reset_wait_rd();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
